buzzer_scheduler: RTL

Single-piezo arbiter and pattern sequencer for the watch. Accepts one-cycle request pulses from the key-press path, the hourly chime trigger and the alarm comparator, and grants the piezo to one source at a time by fixed priority: alarm > chime > key. For the granted source it plays a timed beep pattern as a square wave. It runs on the same 1 kHz system clock as the watch timebase, so 1 cycle = 1 ms.

---
 rtl/buzzer_scheduler_pkg.sv | 41 ++++
 rtl/buzzer_scheduler_if.sv | 22 ++
 rtl/buzzer_scheduler_tone_gen.sv | 34 +++
 rtl/buzzer_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/buzzer_scheduler_pkg.sv
// Shared types and constants for the piezo scheduler: FSM states, source codes
// and the chime beep-count clamp.
package buzzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_ON,
    ST_CHIME_ON,
    ST_CHIME_OFF,
    ST_ALARM_ON,
    ST_ALARM_OFF
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_KEY   = 2'd1,
    SRC_CHIME = 2'd2,
    SRC_ALARM = 2'd3
  } src_t;

  localparam logic [3:0] CHIME_MAX_BEEPS = 4'd12;

  // A zero count means "full hour", so it plays the maximum like any oversize value.
  function automatic logic [3:0] clamp_beeps(input logic [3:0] cnt);
    return (cnt == 4'd0 || cnt > CHIME_MAX_BEEPS) ? CHIME_MAX_BEEPS : cnt;
  endfunction

  function automatic src_t state_src(input state_t st);
    case (st)
      ST_KEY_ON:                 return SRC_KEY;
      ST_CHIME_ON, ST_CHIME_OFF: return SRC_CHIME;
      ST_ALARM_ON, ST_ALARM_OFF: return SRC_ALARM;
      default:                   return SRC_NONE;
    endcase
  endfunction

  function automatic logic is_on(input state_t st);
    return (st == ST_KEY_ON) || (st == ST_CHIME_ON) || (st == ST_ALARM_ON);
  endfunction

endpackage

// File: rtl/buzzer_scheduler_if.sv
// Request/status bundle between the watch sources and the piezo scheduler.
interface buzzer_scheduler_if;
  logic       key_trig;
  logic       chime_trig;
  logic [3:0] chime_count;
  logic       alarm_trig;
  logic       alarm_stop;
  logic       piezo;
  logic       busy;
  logic [1:0] active_src;
  logic       done;

  modport master (
    output key_trig, chime_trig, chime_count, alarm_trig, alarm_stop,
    input  piezo, busy, active_src, done
  );

  modport slave (
    input  key_trig, chime_trig, chime_count, alarm_trig, alarm_stop,
    output piezo, busy, active_src, done
  );
endinterface

// File: rtl/buzzer_scheduler_tone_gen.sv
// Registered square-wave generator: restart forces the high level, then the
// output toggles every `half` cycles while enabled and is held low otherwise.
module tone_gen #(
  parameter int HALF_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [HALF_W-1:0] half,
  output logic              wave
);

  logic [HALF_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave <= 1'b0;
      cnt  <= '0;
    end else if (restart) begin
      wave <= 1'b1;
      cnt  <= '0;
    end else if (!en) begin
      wave <= 1'b0;
      cnt  <= '0;
    end else if (cnt == half - HALF_W'(1)) begin
      wave <= ~wave;
      cnt  <= '0;
    end else begin
      cnt <= cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/buzzer_scheduler.sv
// Single-piezo arbiter and beep-pattern sequencer (alarm > chime > key), 1 cycle = 1 ms.
// Key-click source is built only when BUZZER_KEY_BEEP_EN is defined.
module buzzer_scheduler
  import buzzer_pkg::*;
#(
  parameter int KEY_ON_CYC    = 50,
  parameter int CHIME_ON_CYC  = 200,
  parameter int CHIME_OFF_CYC = 300,
  parameter int ALARM_ON_CYC  = 500,
  parameter int ALARM_OFF_CYC = 500,
  parameter int ALARM_MAX_REP = 60,
  parameter int KEY_HALF      = 1,
  parameter int CHIME_HALF    = 2,
  parameter int ALARM_HALF    = 1
) (
  input logic               clk,
  input logic               rst,
  buzzer_scheduler_if.slave bus
);

  localparam int MAX_A   = (KEY_ON_CYC > CHIME_ON_CYC) ? KEY_ON_CYC : CHIME_ON_CYC;
  localparam int MAX_B   = (CHIME_OFF_CYC > ALARM_ON_CYC) ? CHIME_OFF_CYC : ALARM_ON_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > ALARM_OFF_CYC) ? MAX_C : ALARM_OFF_CYC;
  localparam int PH_W    = $clog2(MAX_CYC);
  localparam int REP_W   = $clog2(ALARM_MAX_REP + 1);
  localparam int HMAX_A  = (KEY_HALF > CHIME_HALF) ? KEY_HALF : CHIME_HALF;
  localparam int HMAX    = (HMAX_A > ALARM_HALF) ? HMAX_A : ALARM_HALF;
  localparam int HALF_W  = $clog2(HMAX + 1);

  state_t            state, state_nx;
  logic [PH_W-1:0]   ph, ph_nx, ph_last;
  logic [3:0]        beeps, beeps_nx;
  logic [REP_W-1:0]  rep, rep_nx;
  logic              pend, pend_nx;
  logic [3:0]        pend_cnt, pend_cnt_nx;
  logic              done_nx;
  logic              ph_end, in_alarm, alarm_exit, alarm_go, key_req, enter;
  logic              busy_r, done_r, piezo_w;
  logic [1:0]        src_r;
  logic [HALF_W-1:0] half_sel;

`ifdef BUZZER_KEY_BEEP_EN
  assign key_req = bus.key_trig;
`else
  logic key_unused;
  assign key_req    = 1'b0;
  assign key_unused = bus.key_trig;
`endif

  always_comb begin
    case (state)
      ST_KEY_ON:    ph_last = PH_W'(KEY_ON_CYC - 1);
      ST_CHIME_ON:  ph_last = PH_W'(CHIME_ON_CYC - 1);
      ST_CHIME_OFF: ph_last = PH_W'(CHIME_OFF_CYC - 1);
      ST_ALARM_ON:  ph_last = PH_W'(ALARM_ON_CYC - 1);
      ST_ALARM_OFF: ph_last = PH_W'(ALARM_OFF_CYC - 1);
      default:      ph_last = '0;
    endcase
  end

  assign ph_end     = (ph == ph_last);
  assign in_alarm   = (state == ST_ALARM_ON) || (state == ST_ALARM_OFF);
  assign alarm_go   = bus.alarm_trig & ~bus.alarm_stop;
  assign alarm_exit = bus.alarm_stop ||
                      (state == ST_ALARM_OFF && ph_end && rep == REP_W'(ALARM_MAX_REP - 1));

  always_comb begin
    state_nx    = state;
    beeps_nx    = beeps;
    rep_nx      = rep;
    pend_nx     = pend;
    pend_cnt_nx = pend_cnt;
    done_nx     = 1'b0;
    if (in_alarm) begin
      // A chime arriving on the exit edge counts as pending, so it chains directly.
      if (alarm_exit) begin
        done_nx = ~bus.alarm_stop;
        if (pend || bus.chime_trig) begin
          state_nx = ST_CHIME_ON;
          beeps_nx = bus.chime_trig ? clamp_beeps(bus.chime_count) : pend_cnt;
          pend_nx  = 1'b0;
        end else begin
          state_nx = ST_IDLE;
        end
      end else begin
        if (bus.chime_trig) begin
          pend_nx     = 1'b1;
          pend_cnt_nx = clamp_beeps(bus.chime_count);
        end
        if (ph_end) begin
          if (state == ST_ALARM_ON) begin
            state_nx = ST_ALARM_OFF;
          end else begin
            state_nx = ST_ALARM_ON;
            rep_nx   = rep + REP_W'(1);
          end
        end
      end
    end else if (alarm_go) begin
      state_nx = ST_ALARM_ON;
      rep_nx   = '0;
      if (bus.chime_trig) begin
        pend_nx     = 1'b1;
        pend_cnt_nx = clamp_beeps(bus.chime_count);
      end
    end else if ((state == ST_IDLE || state == ST_KEY_ON) && bus.chime_trig) begin
      state_nx = ST_CHIME_ON;
      beeps_nx = clamp_beeps(bus.chime_count);
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_req) state_nx = ST_KEY_ON;
        end
        ST_KEY_ON: begin
          if (ph_end) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end
        end
        ST_CHIME_ON: begin
          if (ph_end) begin
            if (beeps == 4'd1) begin
              state_nx = ST_IDLE;
              done_nx  = 1'b1;
            end else begin
              state_nx = ST_CHIME_OFF;
              beeps_nx = beeps - 4'd1;
            end
          end
        end
        ST_CHIME_OFF: begin
          if (ph_end) state_nx = ST_CHIME_ON;
        end
        default: ;
      endcase
    end
  end

  assign enter = (state_nx != state);
  assign ph_nx = (enter || state_nx == ST_IDLE) ? '0 : ph + PH_W'(1);

  always_comb begin
    case (state_src(state_nx))
      SRC_KEY:   half_sel = HALF_W'(KEY_HALF);
      SRC_CHIME: half_sel = HALF_W'(CHIME_HALF);
      default:   half_sel = HALF_W'(ALARM_HALF);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ph       <= '0;
      beeps    <= '0;
      rep      <= '0;
      pend     <= 1'b0;
      pend_cnt <= '0;
      busy_r   <= 1'b0;
      src_r    <= '0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      ph       <= ph_nx;
      beeps    <= beeps_nx;
      rep      <= rep_nx;
      pend     <= pend_nx;
      pend_cnt <= pend_cnt_nx;
      busy_r   <= (state_nx != ST_IDLE);
      src_r    <= state_src(state_nx);
      done_r   <= done_nx;
    end
  end

  tone_gen #(.HALF_W(HALF_W)) u_tone (
    .clk     (clk),
    .rst     (rst),
    .en      (is_on(state_nx)),
    .restart (enter && is_on(state_nx)),
    .half    (half_sel),
    .wave    (piezo_w)
  );

  assign bus.piezo      = piezo_w;
  assign bus.busy       = busy_r;
  assign bus.active_src = src_r;
  assign bus.done       = done_r;

endmodule
